// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the LFSR sequence generator family.
// Default tap masks and fill values per supported width, plus slot index sizing.
package lfsr_pkg;

    localparam logic [7:0]  TAPS_8  = 8'h1D;
    localparam logic [7:0]  FILL_8  = 8'hA5;
    localparam logic [15:0] TAPS_16 = 16'h002D;
    localparam logic [15:0] FILL_16 = 16'hACE1;
    localparam logic [31:0] TAPS_32 = 32'h0000_0057;
    localparam logic [31:0] FILL_32 = 32'hACE1_5EED;

    // A single slot still needs a 1-bit index port.
    function automatic int slot_w(input int slots);
        return (slots > 1) ? $clog2(slots) : 1;
    endfunction

endpackage

// File: rtl/lfsr_advance.sv
// Combinational Fibonacci LFSR advance: applies OUT_BITS shifts in one pass,
// each shift feeding back the XOR of the tapped bits of the intermediate state.
module lfsr_advance #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] TAPS     = 16'h002D,
    parameter int               OUT_BITS = 2
) (
    input  logic [WIDTH-1:0] state_in,
    output logic [WIDTH-1:0] state_out
);

    logic [WIDTH-1:0] s;

    always_comb begin
        s = state_in;
        for (int i = 0; i < OUT_BITS; i++) begin
            s = {^(s & TAPS), s[WIDTH-1:1]};
        end
        state_out = s;
    end

endmodule

// File: rtl/lfsr_seq_gen.sv
// Symbol generator for the Simon game: LFSR state, snapshot slots for replay,
// free-run entropy mode with auto-save on release, and a saturating position count.
module lfsr_seq_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] TAPS     = TAPS_16,
    parameter logic [WIDTH-1:0] FILL     = FILL_16,
    parameter int               OUT_BITS = 2,
    parameter int               SLOTS    = 4,
    parameter int               POS_W    = 8,
    localparam int              SLOT_W   = slot_w(SLOTS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                step,
    input  logic                free_run,
    input  logic [SLOT_W-1:0]   slot,
    input  logic                save,
    input  logic                load,
    input  logic                seed_valid,
    input  logic [WIDTH-1:0]    seed_data,
    output logic [OUT_BITS-1:0] random,
    output logic [POS_W-1:0]    pos,
    output logic                pos_sat
);

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] state_adv;
    logic [WIDTH-1:0] state_nxt;
    logic [WIDTH-1:0] slot_q [SLOTS];
    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] pos_nxt;
    logic             free_run_d;
    logic             slot_ok;
    logic             snap_we;

    lfsr_advance #(
        .WIDTH    (WIDTH),
        .TAPS     (TAPS),
        .OUT_BITS (OUT_BITS)
    ) u_advance (
        .state_in  (state),
        .state_out (state_adv)
    );

    // Non-power-of-two slot counts leave some index values unbacked.
    assign slot_ok = (32'(slot) < SLOTS);
    assign snap_we = slot_ok && (save || (free_run_d && !free_run));

    always_comb begin
        state_nxt = state;
        pos_nxt   = pos_q;
        if (seed_valid) begin
            state_nxt = (seed_data == '0) ? FILL : seed_data;
            pos_nxt   = '0;
        end else if (load) begin
            if (slot_ok) begin
                state_nxt = slot_q[slot];
                pos_nxt   = '0;
            end
        end else if (step || free_run) begin
            state_nxt = state_adv;
            if (step && (pos_q != '1)) begin
                pos_nxt = pos_q + 1'b1;
            end
        end
        // Guard against the all-zero lock-up state whatever its source.
        if (state_nxt == '0) begin
            state_nxt = FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FILL;
            pos_q      <= '0;
            free_run_d <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                slot_q[i] <= FILL;
            end
        end else begin
            state      <= state_nxt;
            pos_q      <= pos_nxt;
            free_run_d <= free_run;
            if (snap_we) begin
                slot_q[slot] <= state;
            end
        end
    end

    assign random  = state[OUT_BITS-1:0];
    assign pos     = pos_q;
    assign pos_sat = &pos_q;

endmodule
